mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of data paths and the captured read register.
REQ-002 Parameter ADDR_WIDTH, default 32: width of all address ports.
REQ-003 Parameter MEM_LATENCY, default 2: cycles from mem_en to valid mem_rdata; legal range 1..15.
REQ-004 Parameter STARVE_LIMIT, default 4: consecutive data grants allowed while i_req is pending.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-006 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  instruction-fetch read request
- i_addr  in  ADDR_WIDTH  fetch address
- i_gnt  out  1  one-cycle pulse: fetch accepted
- i_done  out  1  one-cycle pulse: fetch data valid on rdata
- d_req  in  1  data-port request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_gnt  out  1  one-cycle pulse: data access accepted
- d_done  out  1  one-cycle pulse: data access complete
- rdata  out  DATA_WIDTH  captured read data, held until next read capture
- mdr_load  out  1  high in the cycle mem_rdata is captured
- mem_en, mem_we  out  1  memory strobe and write enable
- mem_addr  out  ADDR_WIDTH  latched address
- mem_wdata  out  DATA_WIDTH  latched store data
- mem_rdata  in  DATA_WIDTH  memory read data

Function
REQ-007 The FSM SHALL have states IDLE, ACCESS, WAIT and DONE.
REQ-008 Requests SHALL be sampled only in IDLE; a request seen there latches addr/we/wdata and moves the FSM to ACCESS.
REQ-009 Arbitration in IDLE SHALL grant d_req over i_req, except that i_req wins when the starvation counter equals STARVE_LIMIT.
REQ-010 Starvation counter: increments on each data grant while i_req is high; clears on any instruction grant, or on arbitration with i_req low; saturates at STARVE_LIMIT.
REQ-011 ACCESS SHALL last one cycle with mem_en=1, the matching *_gnt=1, mem_we=latched we, and mem_addr/mem_wdata driven from the latched values.
REQ-012 Writes SHALL go ACCESS -> DONE and SHALL never assert mdr_load.
REQ-013 Reads SHALL go ACCESS -> WAIT; WAIT lasts exactly MEM_LATENCY cycles, and its final cycle asserts mdr_load and captures mem_rdata into rdata at the clock edge.
REQ-014 DONE SHALL last one cycle, pulse the granted port's *_done, and then return to IDLE.
REQ-015 Latency from request sampled in IDLE to done SHALL be MEM_LATENCY+2 cycles for a read and 2 cycles for a write.
REQ-016 A requester SHALL drop req in the cycle after its done; if req is still high in IDLE, that is a new request.
REQ-017 Request inputs changing outside IDLE SHALL have no effect, because the latched copies drive memory.
REQ-018 rdata SHALL change only on mdr_load, so its value is stable from done until the next read capture.
REQ-019 mem_en, mem_we, *_gnt, *_done and mdr_load SHALL be 0 in every state not named above.

Reset
REQ-020 While rst is high: FSM = IDLE; all outputs, rdata, the latches and both counters = 0.
REQ-021 Reset mid-access SHALL abandon the access with no done, no mdr_load, and rdata = 0.

Structure
REQ-022 State encoding and the default values of MEM_LATENCY and STARVE_LIMIT SHALL live in the shared package mem_ctrl_pkg.
REQ-023 Priority selection plus the starvation counter SHALL be a sub-module, mem_arbiter; the FSM, latches and capture register stay at top level.

Verification
REQ-024 Single read: MEM_LATENCY=2, i_req with i_addr=0x40, memory returns 0xDEADBEEF -> i_gnt at cycle 1, mdr_load at cycle 3, i_done and rdata=0xDEADBEEF at cycle 4.
REQ-025 Single write: d_req, d_we=1, d_addr=0x80, d_wdata=0x1234 -> mem_en=mem_we=1 with those values at cycle 1, d_done at cycle 2, no mdr_load, rdata unchanged.
REQ-026 Simultaneous i_req and d_req in IDLE -> d_gnt first; i_gnt follows at the next IDLE.
REQ-027 Starvation: d_req and i_req held continuously -> exactly 4 data grants, then 1 instruction grant, then data again.
REQ-028 rst asserted during WAIT -> outputs 0 immediately, no done pulse, and a subsequent read completes normally.
REQ-029 MEM_LATENCY=1 and MEM_LATENCY=15 reads -> done at cycles 3 and 17 respectively.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller: FSM encoding and
// default timing parameters.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_MEM_LATENCY  = 2;
  localparam int DEF_STARVE_LIMIT = 4;

  // Wide enough to count MEM_LATENCY-1 across the full 1..15 latency range.
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Data-over-instruction priority select with a starvation counter that hands
// the fetch port a turn after STARVE_LIMIT back-to-back data grants.
module mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic arb,
  input  logic i_req,
  input  logic d_req,
  output logic grant_i,
  output logic grant_d
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve;
  logic          i_turn;

  assign i_turn  = i_req && (starve == LIMIT);
  assign grant_d = arb && d_req && !i_turn;
  assign grant_i = arb && i_req && (!d_req || i_turn);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (arb) begin
      if (grant_i || !i_req)
        starve <= '0;
      else if (grant_d && (starve != LIMIT))
        starve <= starve + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-port memory access controller shared by an instruction-fetch port and
// a load/store port; reads are captured into rdata after MEM_LATENCY cycles.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mdr_load,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_LATENCY - 1);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    we_q;
  logic                    inst_q;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic                    arb, grant_i, grant_d;

  assign arb       = (state == IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  mem_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arbiter (
    .clk     (clk),
    .rst     (rst),
    .arb     (arb),
    .i_req   (i_req),
    .d_req   (d_req),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Once granted, only these latched copies reach memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      inst_q  <= 1'b0;
    end else if (grant_d) begin
      addr_q  <= d_addr;
      wdata_q <= d_wdata;
      we_q    <= d_we;
      inst_q  <= 1'b0;
    end else if (grant_i) begin
      addr_q  <= i_addr;
      we_q    <= 1'b0;
      inst_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 wait_cnt <= '0;
    else if (state == WAIT)  wait_cnt <= wait_cnt + 1'b1;
    else                     wait_cnt <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           rdata <= '0;
    else if (mdr_load) rdata <= mem_rdata;
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    mdr_load  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_i || grant_d) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        i_gnt     = inst_q;
        d_gnt     = !inst_q;
        state_nxt = we_q ? DONE : WAIT;
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          mdr_load  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        i_done    = inst_q;
        d_done    = !inst_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
